fmul_norm_round48: RTL

- Pipelined normalise-and-round stage of the single-precision multiplier datapath.
- Consumes the raw 48-bit significand product, the 6-bit leading-one position produced by the upstream leading-one finder, and the pre-computed sign and exponent.
- Shifts the significand so its leading one reaches bit 47, adjusts the exponent, rounds to nearest-even and packs an IEEE-754 binary32 result with status flags.
- Valid/ready handshake on both sides, two register stages.

---
 rtl/fmul_norm_round48_pkg.sv | 17 +
 rtl/fmul_norm_round48_fp_round_rne.sv | 14 +
 rtl/fmul_norm_round48.sv | 88 ++++++++
 3 files changed

// File: rtl/fmul_norm_round48_pkg.sv
// fmul_norm_round48_pkg: shared binary32 constants and field/flag structs.
package fmul_norm_round48_pkg;
  localparam int F32_BIAS = 127;
  localparam int F32_EXP_MAX = 255;
  localparam int F32_FRAC_W = 23;
  localparam int PROD_W = 48;
  typedef struct packed {
    logic sign;
    logic [7:0] exp;
    logic [F32_FRAC_W-1:0] frac;
  } f32_t;
  typedef struct packed {
    logic ovf;
    logic unf;
    logic inx;
  } fflags_t;
endpackage

// File: rtl/fmul_norm_round48_fp_round_rne.sv
// fp_round_rne: round-to-nearest-even of a 24-bit significand given guard and sticky.
module fp_round_rne (
  input  logic [23:0] sig,
  input  logic        guard,
  input  logic        sticky,
  output logic [23:0] sig_r,
  output logic        carry,
  output logic        inexact
);
  always_comb begin
    {carry, sig_r} = {1'b0, sig} + 25'(guard & (sticky | sig[0]));
    inexact = guard | sticky;
  end
endmodule

// File: rtl/fmul_norm_round48.sv
// fmul_norm_round48: two-stage normalise, round-to-nearest-even and pack of a 48-bit product.
module fmul_norm_round48
  import fmul_norm_round48_pkg::*;
#(
  parameter int EXP_W = 10,
  parameter bit FTZ = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [PROD_W-1:0] in_mant,
  input  logic [5:0]        in_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_data,
  output logic              out_ovf,
  output logic              out_unf,
  output logic              out_inx
);
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  logic s1_adv, s2_adv, load, zero;
  logic sign_q, sign_d, zero_q, zero_d;
  logic [PROD_W-1:0] norm_q, norm_d;
  logic [EXP_W:0] e1_q, e1_d;
  logic [EXP_W+1:0] e2;
  logic [23:0] sig_r;
  logic carry, rnd_inx;
  f32_t res, data_q, data_d;
  fflags_t flg, flg_q, flg_d;
  fp_round_rne u_rnd (
    .sig(norm_q[PROD_W-1:24]),
    .guard(norm_q[23]),
    .sticky(|norm_q[22:0]),
    .sig_r(sig_r),
    .carry(carry),
    .inexact(rnd_inx)
  );
  always_comb begin
    s2_adv = !s2_valid_q | out_ready;
    s1_adv = !s1_valid_q | s2_adv;
    load = in_valid & s1_adv;
    s1_valid_d = s1_adv ? in_valid : s1_valid_q;
    sign_d = load ? in_sign : sign_q;
    zero_d = load ? (in_mant == '0) : zero_q;
    norm_d = load ? in_mant << (6'(PROD_W - 1) - in_pos) : norm_q;
    e1_d = load ? {in_exp[EXP_W-1], in_exp} + (EXP_W+1)'(in_pos) - (EXP_W+1)'(PROD_W - 2) : e1_q;
    // A normalised nonzero product always has a hidden bit (or a rounding carry).
    zero = zero_q | !(sig_r[23] | carry);
    e2 = {e1_q[EXP_W], e1_q} + (EXP_W+2)'(carry);
    flg.ovf = !zero & !e2[EXP_W+1] & (e2 >= (EXP_W+2)'(F32_EXP_MAX));
    flg.unf = FTZ & !zero & !flg.ovf & (e2[EXP_W+1] | (e2 == '0));
    flg.inx = !zero & (flg.ovf | flg.unf | rnd_inx);
    res.sign = sign_q;
    res.exp = (zero | flg.unf) ? 8'h00 : flg.ovf ? 8'hFF : e2[7:0];
    res.frac = (zero | flg.unf | flg.ovf) ? '0 : sig_r[F32_FRAC_W-1:0];
    s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
    data_d = s2_adv ? res : data_q;
    flg_d = s2_adv ? flg : flg_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      data_q <= '0;
      flg_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      data_q <= data_d;
      flg_q <= flg_d;
    end
  end
  always_ff @(posedge clk) begin
    sign_q <= sign_d;
    zero_q <= zero_d;
    norm_q <= norm_d;
    e1_q <= e1_d;
  end
  assign in_ready = s1_adv;
  assign out_valid = s2_valid_q;
  assign out_data = data_q;
  assign out_ovf = flg_q.ovf;
  assign out_unf = flg_q.unf;
  assign out_inx = flg_q.inx;
endmodule
